// File: rtl/mem_wb_if.sv
// MEM -> WB stage bus: MEM-side instruction fields in, register-file write
// port and retirement status out. The master drives the MEM-side fields.
interface mem_wb_if #(
  parameter int CNT_W = 32
) ();
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [4:0]       in_rd;
  logic             in_regwrite;
  logic             in_memtoreg;
  logic             in_jump;
  logic [2:0]       in_funct3;
  logic [1:0]       in_addr_lo;
  logic [31:0]      in_aluresult;
  logic [31:0]      in_memrdata;
  logic [31:0]      in_pc4;
  logic [4:0]       writereg;
  logic [31:0]      writedata;
  logic             RegWrite;
  logic             wb_valid;
  logic             load_fault;
  logic [CNT_W-1:0] instret;

  modport master (
    output stall, flush, in_valid, in_rd, in_regwrite, in_memtoreg, in_jump,
           in_funct3, in_addr_lo, in_aluresult, in_memrdata, in_pc4,
    input  writereg, writedata, RegWrite, wb_valid, load_fault, instret
  );

  modport slave (
    input  stall, flush, in_valid, in_rd, in_regwrite, in_memtoreg, in_jump,
           in_funct3, in_addr_lo, in_aluresult, in_memrdata, in_pc4,
    output writereg, writedata, RegWrite, wb_valid, load_fault, instret
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: aligns load data, selects the write-back result,
// flags illegal/misaligned loads and counts retired instructions.
module mem_wb_stage #(
  parameter int CNT_W = 32
) (
  input logic     clk,
  input logic     rst,
  mem_wb_if.slave bus
);

  function automatic logic [31:0] load_align(input logic [2:0]  f3,
                                             input logic [1:0]  lo,
                                             input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    b = 8'(word >> {lo, 3'b000});
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'd0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'd0, h};
      3'b010:  res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  function automatic logic load_illegal(input logic [2:0] f3,
                                        input logic [1:0] lo);
    logic bad;
    case (f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = lo[0];
      3'b010:         bad = (lo != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  logic             wb_valid_q, wb_valid_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       writereg_q, writereg_d;
  logic [31:0]      writedata_q, writedata_d;
  logic             load_fault_q;
  logic [CNT_W-1:0] instret_q;
  logic             fault_d;
  logic [31:0]      result_d;

  always_comb begin
    fault_d = bus.in_valid & bus.in_memtoreg & ~bus.in_jump &
              load_illegal(bus.in_funct3, bus.in_addr_lo);
    if (bus.in_jump)
      result_d = bus.in_pc4;
    else if (bus.in_memtoreg)
      result_d = load_align(bus.in_funct3, bus.in_addr_lo, bus.in_memrdata);
    else
      result_d = bus.in_aluresult;
    wb_valid_d  = bus.in_valid;
    regwrite_d  = bus.in_valid & bus.in_regwrite & (bus.in_rd != 5'd0) & ~fault_d;
    writereg_d  = regwrite_d ? bus.in_rd : 5'd0;
    writedata_d = (bus.in_valid & ~fault_d) ? result_d : 32'd0;
  end

  // MEM -> WB boundary: flush inserts a bubble, stall holds everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      writereg_q   <= 5'd0;
      writedata_q  <= 32'd0;
      load_fault_q <= 1'b0;
      instret_q    <= '0;
    end else if (bus.flush) begin
      wb_valid_q  <= 1'b0;
      regwrite_q  <= 1'b0;
      writereg_q  <= 5'd0;
      writedata_q <= 32'd0;
    end else if (!bus.stall) begin
      wb_valid_q   <= wb_valid_d;
      regwrite_q   <= regwrite_d;
      writereg_q   <= writereg_d;
      writedata_q  <= writedata_d;
      load_fault_q <= load_fault_q | fault_d;
      instret_q    <= instret_q + CNT_W'(bus.in_valid);
    end
  end

  assign bus.wb_valid   = wb_valid_q;
  assign bus.RegWrite   = regwrite_q;
  assign bus.writereg   = writereg_q;
  assign bus.writedata  = writedata_q;
  assign bus.load_fault = load_fault_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a 32-bit counter instance for function
// and a 4-bit counter instance for the retirement-count wrap.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic rst;
  logic rst4;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_wb_if #(.CNT_W(32)) bus ();
  mem_wb_if #(.CNT_W(4))  bus4 ();

  mem_wb_stage #(.CNT_W(32)) dut  (.clk(clk), .rst(rst),  .bus(bus));
  mem_wb_stage #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst4), .bus(bus4));

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                       input logic m2r, input logic jmp, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [31:0] alu,
                       input logic [31:0] mrd, input logic [31:0] pc4);
    bus.in_valid = v;      bus.in_rd = rd;          bus.in_regwrite = rw;
    bus.in_memtoreg = m2r; bus.in_jump = jmp;       bus.in_funct3 = f3;
    bus.in_addr_lo = lo;   bus.in_aluresult = alu;  bus.in_memrdata = mrd;
    bus.in_pc4 = pc4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    drive(1, 5'd4, 1, 0, 0, 3'b010, 2'd0, 32'h5555_0000, 32'h0, 32'h0);
    tick();
    drive(1, 5'd6, 1, 0, 0, 3'b011, 2'd1, 32'hFFFF_FFFF, 32'h0, 32'h0);
    rst = 1'b0; bus.stall = 1'b1; bus.flush = 1'b1;
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", bus.wb_valid); end
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b want 0", bus.RegWrite); end
    checks++; if (bus.writereg !== 5'd0) begin errors++; $display("FAIL reset_writereg got %0d want 0", bus.writereg); end
    checks++; if (bus.writedata !== 32'd0) begin errors++; $display("FAIL reset_writedata got %h want 0", bus.writedata); end
    checks++; if (bus.load_fault !== 1'b0) begin errors++; $display("FAIL reset_load_fault got %b want 0", bus.load_fault); end
    checks++; if (bus.instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", bus.instret); end
    rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_alu();
    do_reset();
    drive(1, 5'd5, 1, 0, 0, 3'b000, 2'd0, 32'h0000_1234, 32'hFFFF_FFFF, 32'h40);
    tick();
    checks++; if (bus.writereg !== 5'd5) begin errors++; $display("FAIL alu_writereg got %0d want 5", bus.writereg); end
    checks++; if (bus.writedata !== 32'h0000_1234) begin errors++; $display("FAIL alu_writedata got %h want 00001234", bus.writedata); end
    checks++; if (bus.RegWrite !== 1'b1) begin errors++; $display("FAIL alu_regwrite got %b want 1", bus.RegWrite); end
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid got %b want 1", bus.wb_valid); end
    checks++; if (bus.instret !== 32'd1) begin errors++; $display("FAIL alu_instret got %0d want 1", bus.instret); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b100};
    logic [1:0]  lo  [7] = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1};
    logic [31:0] exp [7] = '{32'hFFFF_FFF3, 32'h0000_0081, 32'hFFFF_8081,
                             32'h0000_82F3, 32'h8081_82F3, 32'hFFFF_FF80,
                             32'h0000_0082};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1, 5'd3, 1, 1, 0, f3[i], lo[i], 32'h1111_1111, 32'h8081_82F3, 32'h0);
      tick();
      checks++; if (bus.writedata !== exp[i]) begin errors++; $display("FAIL load%0d_writedata got %h want %h", i, bus.writedata, exp[i]); end
      checks++; if (bus.RegWrite !== 1'b1) begin errors++; $display("FAIL load%0d_regwrite got %b want 1", i, bus.RegWrite); end
    end
    checks++; if (bus.load_fault !== 1'b0) begin errors++; $display("FAIL loads_no_fault got %b want 0", bus.load_fault); end
    checks++; if (bus.instret !== 32'd7) begin errors++; $display("FAIL loads_instret got %0d want 7", bus.instret); end
  endtask

  task automatic test_fault();
    do_reset();
    drive(1, 5'd7, 1, 1, 0, 3'b010, 2'd1, 32'h0, 32'h8081_82F3, 32'h0);
    tick();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL fault_regwrite got %b want 0", bus.RegWrite); end
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL fault_wb_valid got %b want 1", bus.wb_valid); end
    checks++; if (bus.writedata !== 32'd0) begin errors++; $display("FAIL fault_writedata got %h want 0", bus.writedata); end
    checks++; if (bus.writereg !== 5'd0) begin errors++; $display("FAIL fault_writereg got %0d want 0", bus.writereg); end
    checks++; if (bus.load_fault !== 1'b1) begin errors++; $display("FAIL fault_flag got %b want 1", bus.load_fault); end
    checks++; if (bus.instret !== 32'd1) begin errors++; $display("FAIL fault_instret got %0d want 1", bus.instret); end
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'd8, 1, 0, 0, 3'b000, 2'd0, 32'h100 + i, 32'h0, 32'h0);
      tick();
      checks++; if (bus.load_fault !== 1'b1) begin errors++; $display("FAIL sticky%0d_flag got %b want 1", i, bus.load_fault); end
      checks++; if (bus.RegWrite !== 1'b1) begin errors++; $display("FAIL sticky%0d_regwrite got %b want 1", i, bus.RegWrite); end
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.load_fault !== 1'b1) begin errors++; $display("FAIL sticky_flush got %b want 1", bus.load_fault); end
    // other fault classes: misaligned LH, reserved funct3 011 and 110
    drive(1, 5'd9, 1, 1, 0, 3'b001, 2'd1, 32'h0, 32'h8081_82F3, 32'h0);
    tick();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL lh_mis_regwrite got %b want 0", bus.RegWrite); end
    drive(1, 5'd9, 1, 1, 0, 3'b011, 2'd0, 32'h0, 32'h8081_82F3, 32'h0);
    tick();
    checks++; if (bus.writedata !== 32'd0) begin errors++; $display("FAIL f3_011_writedata got %h want 0", bus.writedata); end
    drive(1, 5'd9, 1, 1, 0, 3'b110, 2'd0, 32'h0, 32'h8081_82F3, 32'h0);
    tick();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL f3_110_regwrite got %b want 0", bus.RegWrite); end
    checks++; if (bus.instret !== 32'd9) begin errors++; $display("FAIL fault_seq_instret got %0d want 9", bus.instret); end
    do_reset();
    checks++; if (bus.load_fault !== 1'b0) begin errors++; $display("FAIL fault_cleared got %b want 0", bus.load_fault); end
    // a jump ignores load alignment entirely
    drive(1, 5'd2, 1, 1, 1, 3'b010, 2'd3, 32'h0, 32'h0, 32'h0000_0200);
    tick();
    checks++; if (bus.load_fault !== 1'b0) begin errors++; $display("FAIL jump_no_fault got %b want 0", bus.load_fault); end
    checks++; if (bus.writedata !== 32'h0000_0200) begin errors++; $display("FAIL jump_over_load got %h want 00000200", bus.writedata); end
    // misaligned word with memtoreg=0 is a plain ALU op
    drive(1, 5'd2, 1, 0, 0, 3'b010, 2'd1, 32'h0000_0ABC, 32'h0, 32'h0);
    tick();
    checks++; if (bus.load_fault !== 1'b0) begin errors++; $display("FAIL alu_misaligned_fault got %b want 0", bus.load_fault); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    drive(1, 5'd9, 1, 0, 0, 3'b000, 2'd0, 32'h0000_00AA, 32'h0, 32'h0);
    tick();
    bus.stall = 1'b1;
    drive(1, 5'd12, 1, 0, 0, 3'b000, 2'd0, 32'h0000_0BBB, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.writereg !== 5'd9) begin errors++; $display("FAIL stall%0d_writereg got %0d want 9", i, bus.writereg); end
      checks++; if (bus.writedata !== 32'h0000_00AA) begin errors++; $display("FAIL stall%0d_writedata got %h want 000000aa", i, bus.writedata); end
      checks++; if (bus.RegWrite !== 1'b1) begin errors++; $display("FAIL stall%0d_regwrite got %b want 1", i, bus.RegWrite); end
      checks++; if (bus.instret !== 32'd1) begin errors++; $display("FAIL stall%0d_instret got %0d want 1", i, bus.instret); end
    end
    bus.flush = 1'b1;
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb_valid got %b want 0", bus.wb_valid); end
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL flush_regwrite got %b want 0", bus.RegWrite); end
    checks++; if (bus.writereg !== 5'd0) begin errors++; $display("FAIL flush_writereg got %0d want 0", bus.writereg); end
    checks++; if (bus.writedata !== 32'd0) begin errors++; $display("FAIL flush_writedata got %h want 0", bus.writedata); end
    checks++; if (bus.instret !== 32'd1) begin errors++; $display("FAIL flush_instret got %0d want 1", bus.instret); end
    bus.flush = 1'b0; bus.stall = 1'b0;
    tick();
    checks++; if (bus.writedata !== 32'h0000_0BBB) begin errors++; $display("FAIL post_flush_writedata got %h want 00000bbb", bus.writedata); end
    checks++; if (bus.instret !== 32'd2) begin errors++; $display("FAIL post_flush_instret got %0d want 2", bus.instret); end
  endtask

  task automatic test_jump_x0();
    do_reset();
    drive(1, 5'd1, 1, 0, 1, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0000_0104);
    tick();
    checks++; if (bus.writedata !== 32'h0000_0104) begin errors++; $display("FAIL jal_writedata got %h want 00000104", bus.writedata); end
    checks++; if (bus.writereg !== 5'd1) begin errors++; $display("FAIL jal_writereg got %0d want 1", bus.writereg); end
    drive(1, 5'd0, 1, 0, 0, 3'b000, 2'd0, 32'h0000_0077, 32'h0, 32'h0);
    tick();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL x0_regwrite got %b want 0", bus.RegWrite); end
    checks++; if (bus.writereg !== 5'd0) begin errors++; $display("FAIL x0_writereg got %0d want 0", bus.writereg); end
    checks++; if (bus.instret !== 32'd2) begin errors++; $display("FAIL x0_instret got %0d want 2", bus.instret); end
    drive(0, 5'd4, 1, 0, 0, 3'b000, 2'd0, 32'h0000_0055, 32'h0, 32'h0);
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL bubble_wb_valid got %b want 0", bus.wb_valid); end
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL bubble_regwrite got %b want 0", bus.RegWrite); end
    checks++; if (bus.writedata !== 32'd0) begin errors++; $display("FAIL bubble_writedata got %h want 0", bus.writedata); end
    checks++; if (bus.instret !== 32'd2) begin errors++; $display("FAIL bubble_instret got %0d want 2", bus.instret); end
  endtask

  task automatic test_wrap();
    rst4 = 1'b0; bus4.stall = 1'b0; bus4.flush = 1'b0;
    bus4.in_valid = 1'b1; bus4.in_rd = 5'd3; bus4.in_regwrite = 1'b1;
    bus4.in_memtoreg = 1'b0; bus4.in_jump = 1'b0; bus4.in_funct3 = 3'b000;
    bus4.in_addr_lo = 2'd0; bus4.in_aluresult = 32'h1; bus4.in_memrdata = 32'h0;
    bus4.in_pc4 = 32'h0;
    tick();
    rst4 = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (bus4.instret !== 4'hF) begin errors++; $display("FAIL wrap_allones got %0d want 15", bus4.instret); end
    tick();
    checks++; if (bus4.instret !== 4'h0) begin errors++; $display("FAIL wrap_zero got %0d want 0", bus4.instret); end
  endtask

  initial begin
    rst = 1'b0; rst4 = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    drive(0, 5'd0, 0, 0, 0, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_alu();
    test_loads();
    test_fault();
    test_stall_flush();
    test_jump_x0();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
